mem_port_arbiter: RTL

- Shares one single-port unified memory between the IF-stage instruction fetch and the MEM-stage data access (load/store) of the 5-stage pipeline.
- Arbitrates round-robin when both requesters are pending.
- Drives a registered req/ready memory handshake, returns read data, and gives each stage a stall signal for the pipeline hazard logic.
- Sits between the pipeline registers and the memory model; replaces separate instruction and data memories.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data access, with a registered req/ready handshake and a per-grant timeout.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, RESP} state_t;
  typedef enum logic {INSTR, DATA} grant_t;

  state_t           state;
  grant_t           last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic             dm_load;
  logic             dm_pend;
  logic             pick_d;
  logic             timed_out;

  assign dm_pend   = dm_read | dm_write;
  // On a tie the side that did not win last time gets the memory.
  assign pick_d    = dm_pend & (~if_req | (last_grant == INSTR));
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign if_stall  = if_req & ~if_ack;
  assign dm_stall  = dm_pend & ~dm_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= INSTR;
      wait_cnt    <= '0;
      dm_load     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state      <= GNT_D;
            last_grant <= DATA;
            mem_req    <= 1'b1;
            mem_we     <= dm_write;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            // Read+write together is a store, so no load data is captured.
            dm_load    <= dm_read & ~dm_write;
          end else if (if_req) begin
            state      <= GNT_I;
            last_grant <= INSTR;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
          end
        end
        GNT_D, GNT_I: begin
          if (mem_ready || timed_out) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (state == GNT_I) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              dm_ack <= 1'b1;
              if (dm_load) dm_rdata <= mem_ready ? mem_rdata : '0;
            end
            if (!mem_ready) timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          // One dead cycle lets the requester retire its request before resampling.
          state    <= IDLE;
          if_ack   <= 1'b0;
          dm_ack   <= 1'b0;
          wait_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
